// File: rtl/dmem_access_arbiter.sv
// dmem_access_arbiter: round-robin sharing of a single-port data memory between CPU and DMA/debug ports
// Sub-word stores are turned into read-modify-write sequences, so the memory only ever sees full-word writes.
// Ports:
//   clock, reset_n                        rising-edge clock, asynchronous active-low reset
//   c_req/c_we/c_addr/c_be/c_wdata/c_ack  CPU port (req held until the one-cycle ack)
//   d_req/d_we/d_addr/d_be/d_wdata/d_ack  DMA/debug port, same protocol
//   rdata                                 word read by the completed access, valid with *_ack
//   busy                                  high whenever an access is in progress
//   mem_addr/mem_write/mem_wdata/mem_len  drive the memory's addr/write/data/length inputs
//   mem_rdata                             combinational read data from the memory
module dmem_access_arbiter #(
    parameter int         AW        = 7,
    parameter logic [1:0] WR_ON     = 2'b01,
    parameter logic [1:0] WR_OFF    = 2'b00,
    parameter logic [2:0] LEN_DWORD = 3'b000
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [3:0]    c_be,
    input  logic [31:0]   c_wdata,
    output logic          c_ack,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [3:0]    d_be,
    input  logic [31:0]   d_wdata,
    output logic          d_ack,
    output logic [31:0]   rdata,
    output logic          busy,
    output logic [AW-1:0] mem_addr,
    output logic [1:0]    mem_write,
    output logic [31:0]   mem_wdata,
    output logic [2:0]    mem_len,
    input  logic [31:0]   mem_rdata
);
    typedef enum logic [1:0] {IDLE, RD, WR, ACK} state_t;
    state_t      state;
    logic        last_grant;
    logic        gnt;
    logic        l_we;
    logic [3:0]  l_be;
    logic [31:0] l_wdata;
    logic        pick_d;
    logic [31:0] merged;
    // On a conflict the port that was not granted last time wins.
    assign pick_d  = d_req && (!c_req || !last_grant);
    assign mem_len = LEN_DWORD;
    // Write word for the RMW: enabled lanes from the store data, the rest from the word being read.
    always_comb begin
        merged = mem_rdata;
        for (int i = 0; i < 4; i++)
            merged[8*i +: 8] = l_be[i] ? l_wdata[8*i +: 8] : mem_rdata[8*i +: 8];
    end
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            gnt        <= 1'b0;
            l_we       <= 1'b0;
            l_be       <= 4'h0;
            l_wdata    <= 32'h0;
            c_ack      <= 1'b0;
            d_ack      <= 1'b0;
            busy       <= 1'b0;
            rdata      <= 32'h0;
            mem_addr   <= '0;
            mem_write  <= WR_OFF;
            mem_wdata  <= 32'h0;
        end else begin
            case (state)
                IDLE: if (c_req || d_req) begin
                    gnt        <= pick_d;
                    last_grant <= pick_d;
                    l_we       <= pick_d ? d_we : c_we;
                    l_be       <= pick_d ? d_be : c_be;
                    l_wdata    <= pick_d ? d_wdata : c_wdata;
                    mem_addr   <= pick_d ? d_addr : c_addr;
                    busy       <= 1'b1;
                    state      <= RD;
                end
                RD: begin
                    rdata <= mem_rdata;
                    // A store with no enabled bytes completes like a load and never writes.
                    if (l_we && l_be != 4'h0) begin
                        mem_wdata <= merged;
                        mem_write <= WR_ON;
                        state     <= WR;
                    end else begin
                        c_ack <= !gnt;
                        d_ack <= gnt;
                        state <= ACK;
                    end
                end
                WR: begin
                    mem_write <= WR_OFF;
                    c_ack     <= !gnt;
                    d_ack     <= gnt;
                    state     <= ACK;
                end
                default: begin
                    c_ack <= 1'b0;
                    d_ack <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_access_arbiter.sv
// tb_dmem_access_arbiter: scoreboard bench for dmem_access_arbiter with a word-level memory reference
module tb_dmem_access_arbiter;
    localparam logic [1:0] WR_ON  = 2'b01;
    localparam logic [1:0] WR_OFF = 2'b00;
    logic        clock = 0;
    logic        reset_n = 1;
    logic        c_req = 0, c_we = 0, d_req = 0, d_we = 0;
    logic [6:0]  c_addr = 0, d_addr = 0;
    logic [3:0]  c_be = 0, d_be = 0;
    logic [31:0] c_wdata = 0, d_wdata = 0;
    logic        c_ack, d_ack, busy;
    logic [31:0] rdata, mem_wdata, mem_rdata;
    logic [6:0]  mem_addr;
    logic [1:0]  mem_write;
    logic [2:0]  mem_len;
    logic [31:0] mem [128];
    logic [31:0] ref_mem [128];
    logic        pre_we = 0;
    logic [6:0]  pre_a = 0;
    logic [31:0] pre_d = 0;
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;
    int          wr_cnt = 0;
    bit          last = 1;
    typedef struct {
        bit          port;
        logic [6:0]  addr;
        logic [31:0] exp_rdata;
        logic [31:0] exp_mem;
        int          exp_wr;
        int          exp_cyc;
    } exp_t;
    exp_t q[$];

    dmem_access_arbiter dut (
        .clock(clock), .reset_n(reset_n),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_be(c_be), .c_wdata(c_wdata), .c_ack(c_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_be(d_be), .d_wdata(d_wdata), .d_ack(d_ack),
        .rdata(rdata), .busy(busy), .mem_addr(mem_addr), .mem_write(mem_write),
        .mem_wdata(mem_wdata), .mem_len(mem_len), .mem_rdata(mem_rdata)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Memory: combinational read, write committed on the rising edge while WR_ON.
    always @(posedge clock) begin
        if (pre_we) mem[pre_a] <= pre_d;
        else if (mem_write == WR_ON) mem[mem_addr] <= mem_wdata;
    end
    assign mem_rdata = mem[mem_addr];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic poke(input logic [6:0] a, input logic [31:0] v);
        pre_we = 1; pre_a = a; pre_d = v; ref_mem[a] = v;
        @(negedge clock);
        pre_we = 0;
    endtask

    // Reference: a granted access sampled at edge s reads the old word, merges enabled
    // bytes for a store, and acks in cycle 2 (load / empty store) or 3 (store) after s.
    task automatic predict(input bit port, input bit we, input logic [6:0] a, input logic [3:0] be,
                           input logic [31:0] wd, input int s, output int n);
        exp_t e;
        logic [31:0] nw;
        nw = ref_mem[a];
        if (we) for (int i = 0; i < 4; i++) if (be[i]) nw[8*i +: 8] = wd[8*i +: 8];
        n = (we && be != 0) ? 3 : 2;
        e.port = port; e.addr = a; e.exp_rdata = ref_mem[a]; e.exp_mem = nw;
        e.exp_wr = (n == 3) ? 1 : 0;
        e.exp_cyc = s + n - 1;
        ref_mem[a] = nw;
        q.push_back(e);
    endtask

    // mode 0: c only, 1: d only, 2: both together, 3: c then d raised one cycle later
    task automatic access(input int mode,
                          input bit cwe, input logic [6:0] ca, input logic [3:0] cbe, input logic [31:0] cwd,
                          input bit dwe, input logic [6:0] da, input logic [3:0] dbe, input logic [31:0] dwd);
        int s, n1, n2, guard;
        bit cp, dp, first;
        c_we = cwe; c_addr = ca; c_be = cbe; c_wdata = cwd;
        d_we = dwe; d_addr = da; d_be = dbe; d_wdata = dwd;
        s = cyc + 1;
        cp = (mode != 1);
        dp = (mode != 0);
        c_req = cp;
        d_req = dp && mode != 3;
        first = (mode == 1) || (mode == 2 && last == 0);
        if (mode == 0) predict(0, cwe, ca, cbe, cwd, s, n1);
        else if (mode == 1) predict(1, dwe, da, dbe, dwd, s, n1);
        else if (!first) begin
            predict(0, cwe, ca, cbe, cwd, s, n1);
            predict(1, dwe, da, dbe, dwd, s + n1 + 1, n2);
        end else begin
            predict(1, dwe, da, dbe, dwd, s, n1);
            predict(0, cwe, ca, cbe, cwd, s + n1 + 1, n2);
        end
        last = (mode == 0) ? 0 : (mode == 1) ? 1 : !first;
        guard = 0;
        while ((cp || dp) && guard < 30) begin
            @(negedge clock);
            guard++;
            if (mode == 3 && guard == 1) d_req = 1;
            if (c_ack) begin c_req = 0; cp = 0; end
            if (d_ack) begin d_req = 0; dp = 0; end
            // The granted port's inputs change mid-access; only latched values may be used.
            if (!first && cp) begin
                c_we = $urandom; c_addr = $urandom; c_be = $urandom; c_wdata = $urandom;
            end
            if (first && dp) begin
                d_we = $urandom; d_addr = $urandom; d_be = $urandom; d_wdata = $urandom;
            end
        end
        chk("ack_timeout", {31'b0, cp | dp}, 32'd0);
        c_req = 0; d_req = 0;
        @(negedge clock);
    endtask

    // Monitor: pops one expectation per ack pulse.
    always @(negedge clock) begin
        if (!reset_n) wr_cnt = 0;
        else begin
            if (mem_write == WR_ON) wr_cnt++;
            if (c_ack && d_ack) chk("both_ack", 32'd1, 32'd0);
            else if (c_ack || d_ack) begin
                if (q.size() == 0) chk("unexpected_ack", {31'b0, d_ack}, 32'hFFFFFFFF);
                else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("ack_port", {31'b0, d_ack}, {31'b0, e.port});
                    chk("rdata", rdata, e.exp_rdata);
                    chk("ack_cycle", cyc, e.exp_cyc);
                    chk("write_count", wr_cnt, e.exp_wr);
                    chk("mem_word", mem[e.addr], e.exp_mem);
                    chk("mem_len", {29'b0, mem_len}, 32'd0);
                end
                wr_cnt = 0;
            end
        end
    end

    initial begin
        logic [31:0] keep;
        #2 reset_n = 0;
        for (int i = 0; i < 128; i++) poke(i[6:0], $urandom);
        poke(7'd5, 32'hDEADBEEF);
        poke(7'd3, 32'h11223344);
        poke(7'd9, 32'h55667788);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_c_ack", {31'b0, c_ack}, 32'd0);
        chk("rst_d_ack", {31'b0, d_ack}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_mem_write", {30'b0, mem_write}, {30'b0, WR_OFF});
        chk("rst_mem_addr", {25'b0, mem_addr}, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        reset_n = 1;
        @(negedge clock);
        // Conflicts straight out of reset: c, d, c, d.
        access(2, 0, 7'd10, 4'h0, 0, 0, 7'd11, 4'h0, 0);
        access(2, 0, 7'd12, 4'h0, 0, 0, 7'd13, 4'h0, 0);
        access(0, 0, 7'd5, 4'h0, 0, 0, 0, 0, 0);
        access(0, 1, 7'd3, 4'b0010, 32'h0000AA00, 0, 0, 0, 0);
        access(1, 0, 0, 0, 0, 1, 7'd9, 4'h0, 32'hFFFFFFFF);
        access(1, 0, 0, 0, 0, 1, 7'd9, 4'hF, 32'hCAFEF00D);
        access(3, 1, 7'd20, 4'b1001, 32'hA1B2C3D4, 1, 7'd20, 4'b0110, 32'h01020304);
        for (int k = 0; k < 60; k++)
            access($urandom_range(0, 3),
                   1'($urandom), 7'($urandom_range(0, 15)), 4'($urandom), $urandom,
                   1'($urandom), 7'($urandom_range(0, 15)), 4'($urandom), $urandom);
        // Reset in the middle of a full-word write to word 30.
        keep = ref_mem[30];
        c_we = 1; c_addr = 7'd30; c_be = 4'hF; c_wdata = ~keep; c_req = 1;
        @(negedge clock);
        @(negedge clock);
        chk("wr_state_write", {30'b0, mem_write}, {30'b0, WR_ON});
        reset_n = 0;
        c_req = 0;
        #1;
        chk("abort_mem_write", {30'b0, mem_write}, {30'b0, WR_OFF});
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_c_ack", {31'b0, c_ack}, 32'd0);
        @(negedge clock);
        @(negedge clock);
        chk("abort_mem_word", mem[30], keep);
        reset_n = 1;
        last = 1;
        @(negedge clock);
        access(2, 0, 7'd30, 4'h0, 0, 1, 7'd31, 4'h3, 32'h0000BEEF);
        repeat (4) @(negedge clock);
        chk("queue_drained", q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
